// File: rtl/egress_pkg.sv
// Shared types and constants for the egress port.
// Control word layout and FSM state encoding.
package egress_pkg;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 9;
  localparam int PRI_W  = 3;
  localparam int SRC_W  = 4;

  localparam int LEN_LSB = 7;
  localparam int PRI_LSB = 4;
  localparam int SRC_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOP,
    S_CTRL,
    S_DATA,
    S_EOP,
    S_GAP
  } state_t;

  function automatic logic [DATA_W-1:0] ctrl_word(
    input logic [LEN_W-1:0] len,
    input logic [PRI_W-1:0] pri,
    input logic [SRC_W-1:0] src
  );
    logic [DATA_W-1:0] w;
    w = '0;
    w[LEN_LSB +: LEN_W] = len;
    w[PRI_LSB +: PRI_W] = pri;
    w[SRC_LSB +: SRC_W] = src;
    return w;
  endfunction

endpackage

// File: rtl/egress_fifo.sv
// Synchronous data FIFO for the egress port.
// Push when full / pop when empty are ignored.
module egress_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/egress_port.sv
// Egress half of a switch port: header + FIFO data out.
// Optional stats counters under EGRESS_STAT_EN.
module egress_port
  import egress_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STOP_MARGIN = 4,
  parameter int IPG         = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pkt_start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [PRI_W-1:0]  pkt_prior,
  input  logic [SRC_W-1:0]  pkt_src,
  output logic              hdr_rdy,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              xfer_stop,
  input  logic              ready,
  output logic              rd_sop,
  output logic              rd_eop,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic              ovf_err
`ifdef EGRESS_STAT_EN
  ,
  output logic [15:0]       tx_pkt_cnt,
  output logic [31:0]       tx_word_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = (IPG > 1) ? $clog2(IPG) : 1;
  localparam int GAP_LAST = (IPG > 0) ? IPG - 1 : 0;
  localparam logic [CW-1:0] STOP_LVL =
    CW'(DEPTH - STOP_MARGIN);

  state_t             state;
  state_t             state_nx;
  logic [LEN_W-1:0]   len_q;
  logic [PRI_W-1:0]   pri_q;
  logic [SRC_W-1:0]   src_q;
  logic [LEN_W-1:0]   wcnt;
  logic [LEN_W-1:0]   wcnt_inc;
  logic [GW-1:0]      gcnt;
  logic               gap_done;

  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [DATA_W-1:0]  dout;
  logic [CW-1:0]      count;

  logic               sop_nx;
  logic               eop_nx;
  logic               vld_nx;
  logic [DATA_W-1:0]  data_nx;

  assign push     = in_vld && !full;
  assign pop      = (state == S_DATA) && ready && !empty;
  assign wcnt_inc = wcnt + 1'b1;
  assign gap_done = (gcnt == GW'(GAP_LAST));

  egress_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (in_data),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (pkt_start) state_nx = S_SOP;
      S_SOP:  state_nx = S_CTRL;
      S_CTRL: begin
        if (ready)
          state_nx = (len_q == '0) ? S_EOP : S_DATA;
      end
      S_DATA: begin
        if (pop && wcnt_inc == len_q)
          state_nx = S_EOP;
      end
      S_EOP:  state_nx = (IPG == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (gap_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // next values of the registered egress outputs
  always_comb begin
    sop_nx  = 1'b0;
    eop_nx  = 1'b0;
    vld_nx  = 1'b0;
    data_nx = '0;
    unique case (state)
      S_IDLE: sop_nx = pkt_start;
      S_CTRL: begin
        if (ready) begin
          vld_nx  = 1'b1;
          data_nx = ctrl_word(len_q, pri_q, src_q);
        end
      end
      S_DATA: begin
        if (pop) begin
          vld_nx  = 1'b1;
          data_nx = dout;
        end
      end
      S_EOP:  eop_nx = 1'b1;
      default: ;
    endcase
  end

  // header latch, word and gap counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      pri_q <= '0;
      src_q <= '0;
      wcnt  <= '0;
      gcnt  <= '0;
    end else begin
      if (state == S_IDLE && pkt_start) begin
        len_q <= pkt_len;
        pri_q <= pkt_prior;
        src_q <= pkt_src;
      end
      if (state == S_CTRL)  wcnt <= '0;
      else if (pop)         wcnt <= wcnt_inc;
      if (state == S_EOP)      gcnt <= '0;
      else if (state == S_GAP) gcnt <= gcnt + 1'b1;
    end
  end

  // registered outputs and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sop    <= 1'b0;
      rd_eop    <= 1'b0;
      rd_vld    <= 1'b0;
      rd_data   <= '0;
      hdr_rdy   <= 1'b1;
      xfer_stop <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      rd_sop    <= sop_nx;
      rd_eop    <= eop_nx;
      rd_vld    <= vld_nx;
      rd_data   <= data_nx;
      hdr_rdy   <= (state_nx == S_IDLE);
      xfer_stop <= (count >= STOP_LVL);
      if (in_vld && full) ovf_err <= 1'b1;
    end
  end

`ifdef EGRESS_STAT_EN
  // packet and beat statistics, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_pkt_cnt  <= '0;
      tx_word_cnt <= '0;
    end else begin
      if (eop_nx) tx_pkt_cnt  <= tx_pkt_cnt + 1'b1;
      if (vld_nx) tx_word_cnt <= tx_word_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_egress_port.sv
// Randomized self-checking bench for egress_port.
// Transaction-level reference model plus literal spot checks.
module tb_egress_port;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;
  localparam int IPG    = 2;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        pkt_start = 0;
  logic [8:0]  pkt_len = 0;
  logic [2:0]  pkt_prior = 0;
  logic [3:0]  pkt_src = 0;
  logic        in_vld = 0;
  logic [15:0] in_data = 0;
  logic        ready = 0;
  logic        hdr_rdy;
  logic        xfer_stop;
  logic        rd_sop;
  logic        rd_eop;
  logic        rd_vld;
  logic [15:0] rd_data;
  logic        ovf_err;
`ifdef EGRESS_STAT_EN
  logic [15:0] tx_pkt_cnt;
  logic [31:0] tx_word_cnt;
`endif

  always #5 clk = ~clk;

  egress_port #(
    .DEPTH       (DEPTH),
    .STOP_MARGIN (MARGIN),
    .IPG         (IPG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pkt_start   (pkt_start),
    .pkt_len     (pkt_len),
    .pkt_prior   (pkt_prior),
    .pkt_src     (pkt_src),
    .hdr_rdy     (hdr_rdy),
    .in_vld      (in_vld),
    .in_data     (in_data),
    .xfer_stop   (xfer_stop),
    .ready       (ready),
    .rd_sop      (rd_sop),
    .rd_eop      (rd_eop),
    .rd_vld      (rd_vld),
    .rd_data     (rd_data),
    .ovf_err     (ovf_err)
`ifdef EGRESS_STAT_EN
    ,
    .tx_pkt_cnt  (tx_pkt_cnt),
    .tx_word_cnt (tx_word_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] q[$];
  bit          busy = 0;
  int          edge_n = 0;
  int          start_e = 0;
  int          beats_left = 0;
  int          len_m = 0;
  int          eop_e = -1;
  int          occ;
  logic [15:0] ctrl_m = 0;
  logic        e_sop = 0, e_eop = 0, e_vld = 0;
  logic        e_hdr = 1, e_xs = 0, e_ovf = 0;
  logic [15:0] e_data = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      busy = 0; beats_left = 0; eop_e = -1;
      e_sop = 0; e_eop = 0; e_vld = 0; e_data = 0;
      e_hdr = 1; e_xs = 0; e_ovf = 0;
    end else begin
      edge_n++;
      occ = q.size();
      e_sop = 0; e_eop = 0; e_vld = 0; e_data = 0;
      e_xs = (occ >= DEPTH - MARGIN);
      if (!busy) begin
        if (pkt_start) begin
          busy = 1;
          start_e = edge_n;
          len_m = int'(pkt_len);
          beats_left = len_m + 1;
          ctrl_m = {pkt_len, pkt_prior, pkt_src};
          eop_e = -1;
          e_sop = 1;
        end
      end else if (beats_left > 0) begin
        if (edge_n >= start_e + 2 && ready) begin
          if (beats_left == len_m + 1) begin
            e_vld = 1; e_data = ctrl_m; beats_left--;
          end else if (occ > 0) begin
            e_vld = 1; e_data = q.pop_front();
            beats_left--;
          end
        end
      end else if (eop_e < 0) begin
        e_eop = 1;
        eop_e = edge_n;
      end else if (edge_n >= eop_e + IPG) begin
        busy = 0;
      end
      if (in_vld) begin
        if (occ < DEPTH) q.push_back(in_data);
        else             e_ovf = 1;
      end
      e_hdr = !busy;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    chk("rd_sop", rd_sop, e_sop);
    chk("rd_eop", rd_eop, e_eop);
    chk("rd_vld", rd_vld, e_vld);
    if (e_vld) chk("rd_data", rd_data, e_data);
    chk("hdr_rdy", hdr_rdy, e_hdr);
    chk("xfer_stop", xfer_stop, e_xs);
    chk("ovf_err", ovf_err, e_ovf);
  end

  // ---------------- monitor log ----------------
  int          cyc = 0;
  int          sop_c = 0, eop_c = 0, hdr_c = 0;
  logic        hdr_prev = 1;
  logic [15:0] beat_log[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rd_vld) beat_log.push_back(rd_data);
    if (rd_sop) sop_c = cyc;
    if (rd_eop) eop_c = cyc;
    if (hdr_rdy && !hdr_prev) hdr_c = cyc;
    hdr_prev = hdr_rdy;
  end

  // ---------------- fabric and sink drivers ----------------
  logic [15:0] feed_q[$];
  bit          ign_stop = 0;
  int          ready_mode = 0;
  int          feed_pct = 100;

  always @(negedge clk) begin
    case (ready_mode)
      0: ready = 1'b0;
      1: ready = 1'b1;
      2: ready = cyc[1];
      default: ready = ($urandom_range(0, 99) < 70);
    endcase
    if (feed_q.size() > 0 && (ign_stop || !xfer_stop)
        && $urandom_range(0, 99) < feed_pct) begin
      in_vld  = 1'b1;
      in_data = feed_q.pop_front();
    end else begin
      in_vld = 1'b0;
    end
  end

  task automatic feed(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) feed_q.push_back(base + 16'(i));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    @(negedge clk);
    while (feed_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", feed_q.size(), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic send(input int len, input int pri, input int src);
    wait_idle(2000);
    pkt_start = 1'b1;
    pkt_len   = 9'(len);
    pkt_prior = 3'(pri);
    pkt_src   = 4'(src);
    @(negedge clk);
    pkt_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_hdr_rdy", hdr_rdy, 1);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_xfer_stop", xfer_stop, 0);
    chk("rst_ovf_err", ovf_err, 0);
    rst_n = 1'b1;

    // len=3 with words preloaded
    ready_mode = 1;
    feed(3, 16'hA001);
    wait_drain(50);
    repeat (2) @(negedge clk);
    beat_log.delete();
    send(3, 5, 9);
    wait_idle(200);
    repeat (2) @(negedge clk);
    chk("t1_beats", beat_log.size(), 4);
    if (beat_log.size() == 4) begin
      chk("t1_ctrl", beat_log[0], 16'h01D9);
      chk("t1_a1", beat_log[1], 16'hA001);
      chk("t1_a3", beat_log[3], 16'hA003);
    end
    chk("t1_sop_to_eop", eop_c - sop_c, 6);
    chk("t1_gap", hdr_c - eop_c, 2);

    // len=0
    beat_log.delete();
    send(0, 2, 7);
    wait_idle(200);
    repeat (2) @(negedge clk);
    chk("t2_beats", beat_log.size(), 1);
    if (beat_log.size() == 1)
      chk("t2_ctrl", beat_log[0], 16'h0027);
    chk("t2_sop_to_eop", eop_c - sop_c, 3);

    // len=32, ready toggling every 2 cycles
    ready_mode = 2;
    beat_log.delete();
    feed(32, 16'hB000);
    send(32, 1, 3);
    wait_idle(1000);
    repeat (2) @(negedge clk);
    chk("t3_beats", beat_log.size(), 33);
    if (beat_log.size() == 33)
      chk("t3_last", beat_log[32], 16'hB01F);

    // overflow with sink stalled
    ready_mode = 0;
    ign_stop = 1;
    feed(16, 16'hC000);
    wait_drain(100);
    repeat (3) @(negedge clk);
    chk("t4_stop_high", xfer_stop, 1);
    chk("t4_no_ovf_yet", ovf_err, 0);
    feed(1, 16'hC010);
    wait_drain(20);
    repeat (2) @(negedge clk);
    chk("t4_ovf", ovf_err, 1);
    ign_stop = 0;
    ready_mode = 1;
    beat_log.delete();
    send(16, 0, 1);
    wait_idle(300);
    repeat (2) @(negedge clk);
    chk("t4_beats", beat_log.size(), 17);
    if (beat_log.size() == 17)
      chk("t4_last", beat_log[16], 16'hC00F);

    // reset in the middle of a len=40 packet
    beat_log.delete();
    feed(40, 16'hD000);
    send(40, 3, 4);
    n = 0;
    while (beat_log.size() < 12 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t5_progress", 32'(beat_log.size() >= 12), 1);
    feed_q.delete();
    in_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_sop", rd_sop, 0);
    chk("t5_eop", rd_eop, 0);
    chk("t5_vld", rd_vld, 0);
    chk("t5_data", rd_data, 0);
    chk("t5_stop", xfer_stop, 0);
    chk("t5_ovf", ovf_err, 0);
    chk("t5_hdr", hdr_rdy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    beat_log.delete();
    feed(5, 16'hE000);
    send(5, 6, 2);
    wait_idle(300);
    repeat (2) @(negedge clk);
    chk("t5_beats", beat_log.size(), 6);
    if (beat_log.size() == 6)
      chk("t5_first", beat_log[1], 16'hE000);

    // randomized packets
    for (int p = 0; p < 12; p++) begin
      int len;
      len = $urandom_range(0, 40);
      ready_mode = $urandom_range(1, 3);
      feed_pct = $urandom_range(40, 100);
      feed(len, 16'(p * 256));
      send(len, $urandom_range(0, 7), $urandom_range(0, 15));
      wait_idle(3000);
    end
    feed_pct = 100;
    ready_mode = 1;

    // statistics: lens 4, 0, 10
    do_reset();
    feed(14, 16'hF000);
    send(4, 1, 1);
    send(0, 2, 2);
    send(10, 3, 3);
    wait_idle(500);
    repeat (2) @(negedge clk);
`ifdef EGRESS_STAT_EN
    chk("stat_pkts", tx_pkt_cnt, 3);
    chk("stat_words", tx_word_cnt, 17);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
